// File: rtl/cache_line_fill_pkg.sv
// Cache sizing defaults and the clog2 helper, used by the data RAM, the tag RAM and the line-fill engine.
package cache_line_fill_pkg;

    localparam int CACHE_NR_ENTRIES     = 32;
    localparam int CACHE_WORDS_PER_LINE = 8;

    function automatic int myclog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Data-cache line-fill engine: one bus read per word, each word written to the data RAM, then a tag write.
// Define CACHE_FILL_CWF_EN for critical-word-first ordering with an early crit_valid/crit_data return.
module cache_line_fill
    import cache_line_fill_pkg::*;
#(
    parameter int  nr_entries     = CACHE_NR_ENTRIES,
    parameter int  words_per_line = CACHE_WORDS_PER_LINE,
    localparam int addr_bits      = myclog2(nr_entries),
    localparam int wbits          = myclog2(words_per_line),
    localparam int iw             = addr_bits - wbits
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fill_req,
    input  logic [31:0]          fill_addr,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 fill_error,
    output logic                 tag_wr_en,
    output logic [iw-1:0]        tag_index,
    output logic [31:0]          m_addr,
    output logic                 m_access,
    input  logic                 m_ack,
    input  logic                 m_error,
    input  logic [31:0]          m_data,
    output logic                 ram_wr_en,
    output logic [addr_bits-1:0] ram_write_addr,
    output logic [31:0]          ram_write_data,
    output logic [3:0]           ram_bytesel
`ifdef CACHE_FILL_CWF_EN
    ,
    output logic                 crit_valid,
    output logic [31:0]          crit_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BEAT   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam int               bw        = 30 - wbits;
    localparam logic [wbits:0]   last_beat = (wbits + 1)'(words_per_line - 1);

    state_t                 state_q;
    logic [bw-1:0]          base_q;
    logic [wbits-1:0]       offset_q;
    logic [wbits-1:0]       offset_d;
    logic [wbits-1:0]       start_off;
    logic [wbits:0]         cnt_q;
    logic                   access_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   tag_wr_q;
    logic                   ram_wr_q;
    logic [addr_bits-1:0]   ram_addr_q;
    logic [31:0]            ram_data_q;

`ifdef CACHE_FILL_CWF_EN
    logic                   first_q;
    logic                   crit_valid_q;
    logic [31:0]            crit_data_q;
    logic                   unused_addr;

    assign start_off   = fill_addr[wbits+1:2];
    assign unused_addr = ^fill_addr[1:0];
    assign crit_valid  = crit_valid_q;
    assign crit_data   = crit_data_q;
`else
    logic                   unused_addr;

    assign start_off   = '0;
    assign unused_addr = ^fill_addr[wbits+1:0];
`endif

    // Offset wraps inside the line, so a fill never spills into a neighbouring line.
    assign offset_d       = offset_q + wbits'(1);

    assign fill_busy      = busy_q;
    assign fill_done      = done_q;
    assign fill_error     = err_q;
    assign tag_wr_en      = tag_wr_q;
    assign tag_index      = base_q[iw-1:0];
    assign m_access       = access_q;
    assign m_addr         = access_q ? {base_q, offset_q, 2'b00} : 32'h0;
    assign ram_wr_en      = ram_wr_q;
    assign ram_write_addr = ram_addr_q;
    assign ram_write_data = ram_data_q;
    assign ram_bytesel    = ram_wr_q ? 4'hf : 4'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            offset_q     <= '0;
            cnt_q        <= '0;
            access_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tag_wr_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
`ifdef CACHE_FILL_CWF_EN
            first_q      <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tag_wr_q <= 1'b0;
            ram_wr_q <= 1'b0;
`ifdef CACHE_FILL_CWF_EN
            crit_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (fill_req) begin
                        state_q  <= S_BEAT;
                        base_q   <= fill_addr[31:wbits+2];
                        offset_q <= start_off;
                        cnt_q    <= '0;
                        access_q <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef CACHE_FILL_CWF_EN
                        first_q  <= 1'b1;
`endif
                    end
                end
                S_BEAT: begin
                    // Error takes priority over a simultaneous ack; the errored word is dropped.
                    if (m_error) begin
                        state_q  <= S_IDLE;
                        access_q <= 1'b0;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                    end else if (m_ack) begin
                        ram_wr_q   <= 1'b1;
                        ram_addr_q <= {base_q[iw-1:0], offset_q};
                        ram_data_q <= m_data;
                        offset_q   <= offset_d;
                        cnt_q      <= cnt_q + (wbits + 1)'(1);
`ifdef CACHE_FILL_CWF_EN
                        first_q    <= 1'b0;
                        if (first_q) begin
                            crit_valid_q <= 1'b1;
                            crit_data_q  <= m_data;
                        end
`endif
                        if (cnt_q == last_beat) begin
                            state_q  <= S_FINISH;
                            access_q <= 1'b0;
                            done_q   <= 1'b1;
                            tag_wr_q <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    access_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
